inv_sbox_layer_serial: RTL
==========================

INV_SBOX_LAYER_SERIAL -- requirements
Module: inv_sbox_layer_serial

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 4, number of 5-bit state columns inverse-substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clock_i  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request; sampled only in IDLE or DONE.
REQ-005 SHALL have port state_i  input  320 (type_state, words S[0..4] x 64 bits)  state to process, captured on accepted start.
REQ-006 SHALL have port state_o  output  320 (type_state)  working/result state register.
REQ-007 SHALL have port busy_o  output  1  high while in RUN.
REQ-008 SHALL have port done_o  output  1  single-cycle pulse, result valid on state_o.

Function
REQ-009 SHALL implement the inverse Ascon S-box on each column i (0..63), column value {S[0][i],S[1][i],S[2][i],S[3][i],S[4][i]} with S[0] as MSB.
REQ-010 SHALL use inverse table, index 0x00..0x1F: 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02 (hex).
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-012 SHALL, in IDLE or DONE with start_i=1, load state_i into the state register, clear the group counter, go to RUN.
REQ-013 SHALL, in RUN, replace columns [g*COLS_PER_CYCLE +: COLS_PER_CYCLE] with their inverse values each cycle, g = group counter starting at 0 (columns 0..3 first for default).
REQ-014 SHALL use a group counter of width $clog2(64/COLS_PER_CYCLE), incremented every RUN cycle; transition RUN->DONE on the cycle that processes the last group (counter = 64/COLS_PER_CYCLE-1), counter wraps to 0.
REQ-015 SHALL give latency: start accepted at edge k -> done_o=1 during cycle after edge k+64/COLS_PER_CYCLE (16 RUN cycles for default), state_o final at that point.
REQ-016 SHALL hold done_o high for exactly one cycle; DONE -> IDLE on the next edge when start_i=0.
REQ-017 SHALL, in DONE with start_i=1, accept the new request directly (back-to-back, zero dead cycles).
REQ-018 SHALL ignore start_i during RUN; state_i changes during RUN have no effect.
REQ-019 SHALL hold state_o unchanged in IDLE and DONE.
REQ-020 SHALL keep busy_o=1 exactly in RUN, done_o=1 exactly in DONE (Moore outputs).

Reset
REQ-021 SHALL, on reset_i=1 at a rising edge, force IDLE, counter=0, state register=0, busy_o=0, done_o=0, regardless of current state.
REQ-022 SHALL take reset over start_i when both are high; an aborted RUN produces no done_o pulse.
REQ-023 SHALL accept start_i on the first edge after reset_i deasserts.

Structure
REQ-024 SHALL place the inverse S-box table constant in ascon_pack, reusing the existing type_state typedef.
REQ-025 SHALL instantiate sub-module inv_sbox (combinational 5-bit in/5-bit out lookup) COLS_PER_CYCLE times.
REQ-026 SHALL contain no other sub-modules; FSM, counter and state register live in inv_sbox_layer_serial.

Verification
REQ-027 Bench SHALL apply inv_sbox alone, inputs 0x00..0x1F -> outputs per REQ-010 (0x04->0x00, 0x00->0x14, 0x1F->0x02).
REQ-028 Bench SHALL start with state_i all zeros -> after 16 RUN cycles done_o pulses, S[0]=S[2]=FFFF_FFFF_FFFF_FFFF, S[1]=S[3]=S[4]=0.
REQ-029 Bench SHALL round-trip: feed existing sbox-layer output of a random state -> state_o equals original state.
REQ-030 Bench SHALL pulse start_i at RUN cycle 5 with different state_i -> ignored, result and done timing unchanged.
REQ-031 Bench SHALL assert reset_i at RUN cycle 8 -> next cycle IDLE, state_o=0, busy_o=0, no done_o.
REQ-032 Bench SHALL hold start_i=1 continuously -> done_o pulses every 17 cycles, busy_o low only in DONE cycles.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared Ascon types and constants.
// Holds the 320-bit state layout and the inverse S-box table.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

endpackage

// File: rtl/inv_sbox.sv
// Inverse Ascon S-box, one 5-bit column.
// Pure combinational table lookup.
module inv_sbox
  import ascon_pack::*;
(
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);

  assign y_o = INV_SBOX[x_i];

endmodule

// File: rtl/inv_sbox_layer_serial.sv
// Serial inverse S-box layer over the 320-bit Ascon state.
// Processes COLS_PER_CYCLE columns per cycle, lowest columns first.
module inv_sbox_layer_serial
  import ascon_pack::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam int GROUPS = 64 / COLS_PER_CYCLE;
  localparam int CW     = $clog2(GROUPS);

  fsm_e            state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  type_state       data_q, data_d;
  logic [4:0]      col_in  [COLS_PER_CYCLE];
  logic [4:0]      col_out [COLS_PER_CYCLE];
  logic            accept;
  logic            last;

  assign accept = (state_q != RUN) && start_i;
  assign last   = (cnt_q == CW'(GROUPS - 1));

  // Column base of the current group.
  function automatic logic [5:0] col_idx(
    input logic [CW-1:0] g,
    input int            k
  );
    return 6'(int'(g) * COLS_PER_CYCLE + k);
  endfunction

  always_comb begin : gather
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_in[k] = '0;
      for (int w = 0; w < 5; w++)
        col_in[k][4-w] = data_q[w][col_idx(cnt_q, k)];
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_sb
    inv_sbox u_sb (
      .x_i (col_in[k]),
      .y_o (col_out[k])
    );
  end

  always_comb begin : datapath
    data_d = data_q;
    cnt_d  = cnt_q;
    if (accept) begin
      data_d = state_i;
      cnt_d  = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      for (int k = 0; k < COLS_PER_CYCLE; k++)
        for (int w = 0; w < 5; w++)
          data_d[w][col_idx(cnt_q, k)] = col_out[k][4-w];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    busy_o  = (state_q == RUN);
    done_o  = (state_q == DONE);
    state_o = data_q;
  end

endmodule
